// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier among NUM_REQ requesters, one operation in flight.
// Result valid L+2 cycles after accept; the result is held until the granted requester takes it.
module mult_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*32-1:0]  req_a_i,
    input  logic [NUM_REQ*32-1:0]  req_b_i,
    input  logic [NUM_REQ-1:0]     req_up_or_low_i,
    input  logic [NUM_REQ-1:0]     req_sign_i,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    input  logic [NUM_REQ-1:0]     rsp_ready_i,
    output logic [31:0]            rsp_product_o,
    output logic                   rsp_err_o,
    output logic [31:0]            mult_A_o,
    output logic [31:0]            mult_B_o,
    output logic                   mult_up_or_low_o,
    output logic                   mult_sign_o,
    output logic                   mult_enable_o,
    input  logic [31:0]            mult_product_i,
    input  logic                   mult_ready_i,
    output logic                   busy_o,
    output logic                   mult_fault_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   last_grant, gnt_idx;
    logic            gnt_found;
    logic [CW-1:0]   wait_cnt;
    logic [31:0]     a_q, b_q, prod_q;
    logic            up_q, sign_q, err_q, fault_q;
    logic            accept, mult_done, timeout;
    logic [NUM_REQ-1:0] one_hot;

    assign one_hot = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Search starts just above the previous grant so every requester gets a turn.
    always_comb begin
        gnt_idx   = last_grant;
        gnt_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!gnt_found && req_valid_i[(int'(last_grant) + i) % NUM_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'((int'(last_grant) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        mult_done = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (!reset && !fault_q && gnt_found) begin
                    accept  = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                // A done pulse on the last allowed cycle still counts as success.
                if (mult_ready_i) begin
                    mult_done = 1'b1;
                    state_n   = RESP;
                end else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                    timeout = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i[last_grant]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IW'(NUM_REQ - 1);
            a_q        <= '0;
            b_q        <= '0;
            up_q       <= 1'b0;
            sign_q     <= 1'b0;
            wait_cnt   <= '0;
            prod_q     <= '0;
            err_q      <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= gnt_idx;
                a_q        <= req_a_i[32*int'(gnt_idx) +: 32];
                b_q        <= req_b_i[32*int'(gnt_idx) +: 32];
                up_q       <= req_up_or_low_i[gnt_idx];
                sign_q     <= req_sign_i[gnt_idx];
            end
            if (state == ISSUE) wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
            if (mult_done) begin
                prod_q <= mult_product_i;
                err_q  <= 1'b0;
            end else if (timeout) begin
                prod_q  <= '0;
                err_q   <= 1'b1;
                fault_q <= 1'b1;
            end
        end
    end

    assign req_ready_o      = accept ? (one_hot << gnt_idx) : '0;
    assign rsp_valid_o      = (state == RESP) ? (one_hot << last_grant) : '0;
    assign rsp_product_o    = prod_q;
    assign rsp_err_o        = err_q;
    assign mult_A_o         = a_q;
    assign mult_B_o         = b_q;
    assign mult_up_or_low_o = up_q;
    assign mult_sign_o      = sign_q;
    assign mult_enable_o    = (state == ISSUE);
    assign busy_o           = (state != IDLE);
    assign mult_fault_o     = fault_q;
endmodule
